// File: rtl/pe_mac_dbuf.sv
// pe_mac_dbuf: systolic processing element with a double-buffered weight,
// valid-qualified dataflow, a PIPE-deep multiply pipeline, optional saturating
// accumulation, and a runtime weight-stationary / output-stationary mode.
module pe_mac_dbuf #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int PIPE       = 2,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_os,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_load,
    input  logic                  weight_swap,
    output logic [DATA_WIDTH-1:0] weight_out,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic                  act_valid_in,
    output logic [DATA_WIDTH-1:0] act_out,
    output logic                  act_valid_out,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  psum_valid_in,
    input  logic                  drain,
    input  logic                  acc_clear,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  psum_valid_out,
    output logic                  overflow
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] shadow_w;
    logic [DATA_WIDTH-1:0] active_w;

    logic [PW-1:0]        prod_s;
    logic [PW-1:0]        prod_u;
    logic [ACC_WIDTH-1:0] prod_ext;

    logic [ACC_WIDTH-1:0] prod_q [PIPE];
    logic [ACC_WIDTH-1:0] psum_q [PIPE];
    logic [PIPE-1:0]      av_q;
    logic [PIPE-1:0]      pv_q;
    logic [PIPE-1:0]      dr_q;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   ws_res;
    logic [ACC_WIDTH:0]   os_res;

    // Signed ACC_WIDTH add; returns {overflow, result}, result clamped when saturating.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH-1:0] s;
        logic                 ovf;
        s   = a + b;
        ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
        if (ovf && SATURATE != 0) begin
            s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
        return {ovf, s};
    endfunction

    // Weight double buffer: shadow shifts down the column, active feeds the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            // NOTE: non-blocking assignment makes a simultaneous load+swap copy the old shadow.
            if (weight_load) shadow_w <= weight_in;
            if (weight_swap) active_w <= shadow_w;
        end
    end

    assign weight_out = shadow_w;

    // Activation pass-through to the PE on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_out       <= '0;
            act_valid_out <= 1'b0;
        end else begin
            act_out       <= act_in;
            act_valid_out <= act_valid_in;
        end
    end

    // Product of this cycle's act and active weight, extended to ACC_WIDTH; zero when invalid.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        prod_ext = '0;
        prod_s   = {{DATA_WIDTH{act_in[DATA_WIDTH-1]}}, act_in}
                 * {{DATA_WIDTH{active_w[DATA_WIDTH-1]}}, active_w};
        prod_u   = {{DATA_WIDTH{1'b0}}, act_in} * {{DATA_WIDTH{1'b0}}, active_w};
        if (act_valid_in) begin
            prod_ext = signed_mode ? {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s}
                                   : {{(ACC_WIDTH-PW){1'b0}}, prod_u};
        end
    end

    // Multiply pipeline: product, psum and qualifiers travel PIPE stages together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these pipeline arrays are reset so in-flight valids are discarded on reset.
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i] <= '0;
                psum_q[i] <= '0;
            end
            av_q <= '0;
            pv_q <= '0;
            dr_q <= '0;
        end else begin
            prod_q[0] <= prod_ext;
            psum_q[0] <= psum_in;
            av_q[0]   <= act_valid_in;
            pv_q[0]   <= psum_valid_in;
            dr_q[0]   <= drain;
            for (int i = 1; i < PIPE; i++) begin
                prod_q[i] <= prod_q[i-1];
                psum_q[i] <= psum_q[i-1];
                av_q[i]   <= av_q[i-1];
                pv_q[i]   <= pv_q[i-1];
                dr_q[i]   <= dr_q[i-1];
            end
        end
    end

    // Adder-stage sums for both modes.
    always_comb begin
        ws_res = sat_add(pv_q[PIPE-1] ? psum_q[PIPE-1] : '0, prod_q[PIPE-1]);
        os_res = sat_add(acc, prod_q[PIPE-1]);
    end

    // Adder stage: output register, OS accumulator and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            acc            <= '0;
            overflow       <= 1'b0;
        end else begin
            if (!mode_os) begin
                psum_out       <= ws_res[ACC_WIDTH-1:0];
                psum_valid_out <= av_q[PIPE-1] | pv_q[PIPE-1];
            end else if (dr_q[PIPE-1]) begin
                // Drain wins over an incoming psum; a concurrent clear drains zero.
                psum_out       <= acc_clear ? '0 : os_res[ACC_WIDTH-1:0];
                psum_valid_out <= 1'b1;
            end else begin
                psum_out       <= psum_q[PIPE-1];
                psum_valid_out <= pv_q[PIPE-1];
            end

            if (acc_clear) begin
                acc <= '0;
            end else if (mode_os) begin
                if (dr_q[PIPE-1])      acc <= '0;
                else if (av_q[PIPE-1]) acc <= os_res[ACC_WIDTH-1:0];
            end

            if (acc_clear) begin
                overflow <= 1'b0;
            end else if (mode_os ? os_res[ACC_WIDTH] : ws_res[ACC_WIDTH]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_dbuf.sv
// Directed bench for pe_mac_dbuf: a saturating and a wrapping instance share
// stimulus; expected psum_out/overflow/arrival cycle are queued at issue time
// and popped by a monitor whenever psum_valid_out is seen.
module tb_pe_mac_dbuf;

    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int PIPE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode_os, signed_mode;
    logic [DW-1:0] weight_in;
    logic          weight_load, weight_swap;
    logic [DW-1:0] act_in;
    logic          act_valid_in;
    logic [AW-1:0] psum_in;
    logic          psum_valid_in, drain, acc_clear;

    logic [DW-1:0] weight_out_s, act_out_s, weight_out_w, act_out_w;
    logic          act_valid_out_s, act_valid_out_w;
    logic [AW-1:0] psum_s, psum_w;
    logic          pvo_s, pvo_w, ovf_s, ovf_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [AW-1:0] data;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_mac_dbuf #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE(PIPE), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode_os(mode_os), .signed_mode(signed_mode),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .weight_out(weight_out_s), .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(act_out_s), .act_valid_out(act_valid_out_s), .psum_in(psum_in),
        .psum_valid_in(psum_valid_in), .drain(drain), .acc_clear(acc_clear),
        .psum_out(psum_s), .psum_valid_out(pvo_s), .overflow(ovf_s)
    );

    pe_mac_dbuf #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE(PIPE), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mode_os(mode_os), .signed_mode(signed_mode),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .weight_out(weight_out_w), .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(act_out_w), .act_valid_out(act_valid_out_w), .psum_in(psum_in),
        .psum_valid_in(psum_valid_in), .drain(drain), .acc_clear(acc_clear),
        .psum_out(psum_w), .psum_valid_out(pvo_w), .overflow(ovf_w)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pop and compare on every output pulse of each instance.
    always @(negedge clk) begin
        exp_t es;
        exp_t ew;
        if (pvo_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sat unexpected psum_valid_out: psum_out %0h (cycle %0d)", psum_s, cyc);
            end else begin
                es = q_s.pop_front();
                check("sat psum_out", psum_s, es.data);
                check("sat overflow", ovf_s, es.ovf);
                check("sat arrival cycle", cyc, es.cyc);
            end
        end
        if (pvo_w) begin
            if (q_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wrap unexpected psum_valid_out: psum_out %0h (cycle %0d)", psum_w, cyc);
            end else begin
                ew = q_w.pop_front();
                check("wrap psum_out", psum_w, ew.data);
                check("wrap overflow", ovf_w, ew.ovf);
                check("wrap arrival cycle", cyc, ew.cyc);
            end
        end
    end

    // One clock of stimulus; optionally queue the expected result for both instances.
    task automatic step(input logic [DW-1:0] a, input logic av, input logic [AW-1:0] p,
                        input logic pv, input logic dr, input logic clr, input logic ld,
                        input logic [DW-1:0] wv, input logic sw, input logic push,
                        input logic [AW-1:0] exp_s, input logic [AW-1:0] exp_w,
                        input logic exp_ovf);
        act_in = a; act_valid_in = av; psum_in = p; psum_valid_in = pv;
        drain = dr; acc_clear = clr; weight_load = ld; weight_in = wv; weight_swap = sw;
        if (push) begin
            q_s.push_back('{data: exp_s, ovf: exp_ovf, cyc: cyc + PIPE + 1});
            q_w.push_back('{data: exp_w, ovf: exp_ovf, cyc: cyc + PIPE + 1});
        end
        @(posedge clk);
        #1;
        act_in = '0; act_valid_in = 1'b0; psum_in = '0; psum_valid_in = 1'b0;
        drain = 1'b0; acc_clear = 1'b0; weight_load = 1'b0; weight_in = '0; weight_swap = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wload(input logic [DW-1:0] v, input logic sw);
        step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, v, sw, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wswap();
        step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic clear();
        step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic mac(input logic [DW-1:0] a, input logic av, input logic [AW-1:0] p,
                       input logic pv, input logic dr, input logic push, input logic [AW-1:0] e);
        step(a, av, p, pv, dr, 1'b0, 1'b0, '0, 1'b0, push, e, e, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " psum_out"}, psum_s, 0);
        check({tag, " psum_valid_out"}, pvo_s, 0);
        check({tag, " act_out"}, act_out_s, 0);
        check({tag, " act_valid_out"}, act_valid_out_s, 0);
        check({tag, " weight_out"}, weight_out_s, 0);
        check({tag, " overflow"}, ovf_s, 0);
        check({tag, " wrap outputs"},
              {psum_w, pvo_w, ovf_w, act_out_w, act_valid_out_w, weight_out_w}, 0);
    endtask

    initial begin
        mode_os = 1'b0; signed_mode = 1'b1;
        act_in = '0; act_valid_in = 1'b0; psum_in = '0; psum_valid_in = 1'b0;
        drain = 1'b0; acc_clear = 1'b0; weight_load = 1'b0; weight_in = '0; weight_swap = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // WS signed: 100 + (-4 * 3) = 88, three cycles after issue.
        wload(8'd3, 1'b0);
        check("shadow after load", weight_out_s, 8'd3);
        wswap();
        mac(8'hFC, 1'b1, 32'd100, 1'b1, 1'b0, 1'b1, 32'd88);
        check("act_out registered", act_out_s, 8'hFC);
        check("act_valid_out registered", act_valid_out_s, 1'b1);
        mac(8'd0, 1'b0, 32'd7, 1'b1, 1'b0, 1'b1, 32'd7);
        mac(8'd5, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd15);
        mac(8'hFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        idle(PIPE + 2);

        // Unsigned: 255 * 255 = 65025.
        signed_mode = 1'b0;
        wload(8'hFF, 1'b0);
        wswap();
        mac(8'hFF, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd65025);
        mac(8'hFF, 1'b1, 32'd100, 1'b1, 1'b0, 1'b1, 32'd65125);
        idle(PIPE + 2);
        signed_mode = 1'b1;

        // Double buffer.
        wload(8'd2, 1'b0);
        wswap();
        wload(8'd5, 1'b0);
        check("shadow holds 5", weight_out_s, 8'd5);
        mac(8'd10, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd20);
        // Swap in the same cycle as the act: this act still sees weight 2.
        step(8'd10, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'd20, 32'd20, 1'b0);
        mac(8'd10, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd50);
        wload(8'd9, 1'b0);
        wload(8'd7, 1'b1);
        check("shadow after load+swap", weight_out_s, 8'd7);
        mac(8'd10, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd90);
        idle(PIPE + 2);

        // OS accumulate and drain with weight 4.
        mode_os = 1'b1;
        wload(8'd4, 1'b0);
        wswap();
        clear();
        mac(8'd1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        mac(8'd2, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        mac(8'd3, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 32'd24);
        idle(2);
        mac(8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);
        mac(8'd0, 1'b0, 32'd55, 1'b1, 1'b0, 1'b1, 32'd55);
        mac(8'd1, 1'b1, 32'd77, 1'b1, 1'b1, 1'b1, 32'd4);
        // acc becomes 8, then a drain meets acc_clear at the adder stage: drains 0.
        mac(8'd2, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        mac(8'd3, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);
        idle(1);
        clear();
        idle(1);
        mac(8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);
        idle(PIPE + 2);
        mode_os = 1'b0;

        // Saturation vs wrap: weight 4, act 8 -> +32.
        wload(8'd4, 1'b0);
        wswap();
        step(8'd8, 1'b1, 32'h7FFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0,
             1'b1, 32'h7FFF_FFFF, 32'h8000_0010, 1'b1);
        idle(4);
        clear();
        mac(8'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b1, 32'd5);
        step(8'hF8, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0,
             1'b1, 32'h8000_0000, 32'h7FFF_FFF0, 1'b1);
        idle(4);
        clear();
        check("sat overflow after clear", ovf_s, 1'b0);
        check("wrap overflow after clear", ovf_w, 1'b0);

        // Reset with valids in flight: nothing may emerge afterwards.
        mac(8'd1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0);
        mac(8'd2, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-stream reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(PIPE + 3);
        mac(8'd3, 1'b1, 32'd9, 1'b1, 1'b0, 1'b1, 32'd9);
        idle(PIPE + 3);

        check("scoreboard empty", q_s.size() + q_w.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
